// File: rtl/fb_write_port_if.sv
// -----------------------------------------------------------------------------
// fb_write_port_if
//
// Pixel write stream between a draw module (master) and the framebuffer
// write port (slave). A pixel transfers in any cycle where we && ready.
//
// Signals:
//   we     master -> slave  pixel write request
//   x, y   master -> slave  signed pixel coordinates
//   cidx   master -> slave  pixel colour index
//   ready  slave -> master  pixel accepted this cycle when we is high
//   clip   slave -> master  one-cycle pulse: an accepted pixel was off-screen
// -----------------------------------------------------------------------------
interface fb_write_port_if #(
    parameter int CORDW = 16,
    parameter int CIDXW = 4
);
    logic                    we;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic [CIDXW-1:0]        cidx;
    logic                    ready;
    logic                    clip;

    modport master (
        output we,
        output x,
        output y,
        output cidx,
        input  ready,
        input  clip
    );

    modport slave (
        input  we,
        input  x,
        input  y,
        input  cidx,
        output ready,
        output clip
    );
endinterface

// File: rtl/fb_write_port.sv
// -----------------------------------------------------------------------------
// fb_write_port
//
// Framebuffer write responder. Takes signed (x, y, cidx) pixel requests from
// draw modules, discards anything off-screen, and turns the rest into linear
// writes on the framebuffer's system-clock BRAM port. Also contains a
// clear-screen engine that fills the whole buffer with one colour index.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active low
//   pix          pixel stream (slave side): we/x/y/cidx in, ready/clip out
//   clear_start  request a full-buffer fill with clear_cidx (ignored unless idle)
//   clear_cidx   fill colour, sampled together with clear_start
//   busy         clear in progress (draining the pipeline or filling)
//   clear_done   one-cycle pulse when the fill has finished
//   mem_we       memory write enable
//   mem_addr     memory write address (y*WIDTH + x, or fill address)
//   mem_cidx     memory write data
//   cnt_written  pixels written through the pixel path (wraps at 2^32)
//   cnt_clipped  pixels discarded because they were off-screen (wraps)
//
// Pixel path timing: accept at edge N, clip pulse visible after edge N,
// memory write visible after edge N+1. One pixel per cycle, no bubbles.
// -----------------------------------------------------------------------------
module fb_write_port #(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int CIDXW  = 4,
    parameter int ADDRW  = $clog2(WIDTH*HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    fb_write_port_if.slave    pix,
    input  logic              clear_start,
    input  logic [CIDXW-1:0]  clear_cidx,
    output logic              busy,
    output logic              clear_done,
    output logic              mem_we,
    output logic [ADDRW-1:0]  mem_addr,
    output logic [CIDXW-1:0]  mem_cidx,
    output logic [31:0]       cnt_written,
    output logic [31:0]       cnt_clipped
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NPIX - 1);

    // Screen limits held at coordinate width so the range test is a plain
    // signed compare of like-sized operands.
    localparam logic signed [CORDW-1:0] X_LIM = CORDW'(WIDTH);
    localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Clear FSM state
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic             drain_cnt_reg, drain_cnt_next;
    logic [ADDRW-1:0] clr_addr_reg, clr_addr_next;
    logic [CIDXW-1:0] clr_cidx_reg, clr_cidx_next;

    // ------------------------------------------------------------------
    // Pixel pipeline state
    // ------------------------------------------------------------------
    logic signed [CORDW-1:0] x1_reg;
    logic signed [CORDW-1:0] y1_reg;
    logic [CIDXW-1:0]        cidx1_reg;
    logic                    v1_reg;
    logic                    c1_reg;
    logic                    clip_reg;

    logic                    mem_we_reg;
    logic [ADDRW-1:0]        mem_addr_reg;
    logic [CIDXW-1:0]        mem_cidx_reg;
    logic [31:0]             cnt_written_reg;
    logic [31:0]             cnt_clipped_reg;
    logic                    busy_reg;
    logic                    clear_done_reg;

    logic                    ready_int;
    logic                    accept;
    logic signed [CORDW-1:0] in_x;
    logic signed [CORDW-1:0] in_y;
    logic                    in_clip;
    logic [ADDRW-1:0]        lin_addr;

    // A pixel presented alongside clear_start is refused so that nothing new
    // enters the pipeline once a clear has been requested.
    assign ready_int = (state_reg == IDLE) && !clear_start;
    assign accept    = pix.we && ready_int;
    assign pix.ready = ready_int;
    assign pix.clip  = clip_reg;

    assign in_x = pix.x;
    assign in_y = pix.y;

    // Signed compare: large negative values (e.g. -32768) stay negative and
    // are rejected rather than wrapping into the visible range.
    assign in_clip = (in_x < 0) || (in_x >= X_LIM) ||
                     (in_y < 0) || (in_y >= Y_LIM);

    // Only consumed for unclipped pixels, where both coordinates are known
    // to be non-negative, so the unsigned reinterpretation is exact.
    assign lin_addr = ADDRW'(32'(unsigned'(y1_reg)) * 32'(WIDTH) +
                             32'(unsigned'(x1_reg)));

    // ------------------------------------------------------------------
    // Clear FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 1'b0;
            clr_addr_reg  <= '0;
            clr_cidx_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            clr_addr_reg  <= clr_addr_next;
            clr_cidx_reg  <= clr_cidx_next;
        end
    end

    // ------------------------------------------------------------------
    // Clear FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        clr_addr_next  = clr_addr_reg;
        clr_cidx_next  = clr_cidx_reg;

        case (state_reg)
            IDLE: begin
                if (clear_start) begin
                    clr_cidx_next  = clear_cidx;
                    drain_cnt_next = 1'b0;
                    state_next     = DRAIN;
                end
            end
            DRAIN: begin
                // Two cycles: lets the pixels sitting in S1 and S2 reach
                // memory before the first fill write is issued.
                if (drain_cnt_reg) begin
                    clr_addr_next = '0;
                    state_next    = CLEAR;
                end else begin
                    drain_cnt_next = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_addr_reg == LAST_ADDR) begin
                    state_next = DONE;
                end else begin
                    clr_addr_next = clr_addr_reg + ADDRW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel pipeline, memory port and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x1_reg          <= '0;
            y1_reg          <= '0;
            cidx1_reg       <= '0;
            v1_reg          <= 1'b0;
            c1_reg          <= 1'b0;
            clip_reg        <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_cidx_reg    <= '0;
            cnt_written_reg <= '0;
            cnt_clipped_reg <= '0;
            busy_reg        <= 1'b0;
            clear_done_reg  <= 1'b0;
        end else begin
            // S1: capture the request and its on/off-screen verdict.
            v1_reg    <= accept;
            c1_reg    <= in_clip;
            clip_reg  <= accept && in_clip;
            x1_reg    <= in_x;
            y1_reg    <= in_y;
            cidx1_reg <= pix.cidx;

            if (accept && in_clip) begin
                cnt_clipped_reg <= cnt_clipped_reg + 32'd1;
            end

            // S2 / fill: the drain period guarantees these never coincide,
            // so a simple priority select is enough.
            mem_we_reg <= 1'b0;
            if (state_reg == CLEAR) begin
                mem_we_reg   <= 1'b1;
                mem_addr_reg <= clr_addr_reg;
                mem_cidx_reg <= clr_cidx_reg;
            end else if (v1_reg && !c1_reg) begin
                mem_we_reg      <= 1'b1;
                mem_addr_reg    <= lin_addr;
                mem_cidx_reg    <= cidx1_reg;
                cnt_written_reg <= cnt_written_reg + 32'd1;
            end

            // Registered from the next state so they line up with the state
            // they describe.
            busy_reg       <= (state_next == DRAIN) || (state_next == CLEAR);
            clear_done_reg <= (state_next == DONE);
        end
    end

    assign busy        = busy_reg;
    assign clear_done  = clear_done_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_cidx    = mem_cidx_reg;
    assign cnt_written = cnt_written_reg;
    assign cnt_clipped = cnt_clipped_reg;

endmodule

// File: tb/tb_fb_write_port.sv
// -----------------------------------------------------------------------------
// tb_fb_write_port
//
// Two instances: a full-size 320x240 port for the pixel path (single pixel,
// clipping boundaries, streaming rectangle, reset mid-pipeline) and a small
// 20x12 port for the clear engine so that whole clears stay short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fb_write_port;

    localparam int B_W  = 320;
    localparam int B_H  = 240;
    localparam int B_AW = 17;
    localparam int S_W  = 20;
    localparam int S_H  = 12;
    localparam int S_AW = 8;
    localparam int S_N  = S_W * S_H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- full-size instance ----------------
    fb_write_port_if #(.CORDW(16), .CIDXW(4)) bif ();
    logic              b_rst_n;
    logic              b_clear_start;
    logic [3:0]        b_clear_cidx;
    logic              b_busy;
    logic              b_clear_done;
    logic              b_mem_we;
    logic [B_AW-1:0]   b_mem_addr;
    logic [3:0]        b_mem_cidx;
    logic [31:0]       b_cnt_written;
    logic [31:0]       b_cnt_clipped;

    fb_write_port #(.CORDW(16), .WIDTH(B_W), .HEIGHT(B_H), .CIDXW(4)) u_big (
        .clk         (clk),
        .rst_n       (b_rst_n),
        .pix         (bif),
        .clear_start (b_clear_start),
        .clear_cidx  (b_clear_cidx),
        .busy        (b_busy),
        .clear_done  (b_clear_done),
        .mem_we      (b_mem_we),
        .mem_addr    (b_mem_addr),
        .mem_cidx    (b_mem_cidx),
        .cnt_written (b_cnt_written),
        .cnt_clipped (b_cnt_clipped)
    );

    // ---------------- small instance (clear tests) ----------------
    fb_write_port_if #(.CORDW(16), .CIDXW(4)) sif ();
    logic              s_rst_n;
    logic              s_clear_start;
    logic [3:0]        s_clear_cidx;
    logic              s_busy;
    logic              s_clear_done;
    logic              s_mem_we;
    logic [S_AW-1:0]   s_mem_addr;
    logic [3:0]        s_mem_cidx;
    logic [31:0]       s_cnt_written;
    logic [31:0]       s_cnt_clipped;

    fb_write_port #(.CORDW(16), .WIDTH(S_W), .HEIGHT(S_H), .CIDXW(4)) u_small (
        .clk         (clk),
        .rst_n       (s_rst_n),
        .pix         (sif),
        .clear_start (s_clear_start),
        .clear_cidx  (s_clear_cidx),
        .busy        (s_busy),
        .clear_done  (s_clear_done),
        .mem_we      (s_mem_we),
        .mem_addr    (s_mem_addr),
        .mem_cidx    (s_mem_cidx),
        .cnt_written (s_cnt_written),
        .cnt_clipped (s_cnt_clipped)
    );

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_drive(input logic we, input int xv, input int yv, input logic [3:0] c);
        bif.we   = we;
        bif.x    = 16'(xv);
        bif.y    = 16'(yv);
        bif.cidx = c;
    endtask

    task automatic s_drive(input logic we, input int xv, input int yv, input logic [3:0] c);
        sif.we   = we;
        sif.x    = 16'(xv);
        sif.y    = 16'(yv);
        sif.cidx = c;
    endtask

    task automatic b_reset();
        b_rst_n = 1'b0;
        b_clear_start = 1'b0;
        b_drive(1'b0, 0, 0, 4'd0);
        tick();
        b_rst_n = 1'b1;
    endtask

    task automatic s_reset();
        s_rst_n = 1'b0;
        s_clear_start = 1'b0;
        s_drive(1'b0, 0, 0, 4'd0);
        tick();
        s_rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b_rst_n = 1'b0; b_clear_start = 1'b0; b_clear_cidx = 4'd0;
        s_rst_n = 1'b0; s_clear_start = 1'b0; s_clear_cidx = 4'd0;
        b_drive(1'b0, 0, 0, 4'd0);
        s_drive(1'b0, 0, 0, 4'd0);
        tick();
        tick();

        // ---------------- reset state ----------------
        check_value("rst_mem_we",   64'(b_mem_we), 64'(0));
        check_value("rst_mem_addr", 64'(b_mem_addr), 64'(0));
        check_value("rst_clip",     64'(bif.clip), 64'(0));
        check_value("rst_busy",     64'(b_busy), 64'(0));
        check_value("rst_done",     64'(b_clear_done), 64'(0));
        check_value("rst_cnt_w",    64'(b_cnt_written), 64'(0));
        check_value("rst_cnt_c",    64'(b_cnt_clipped), 64'(0));
        check_value("rst_ready",    64'(bif.ready), 64'(1));
        check_value("rst_s_ready",  64'(sif.ready), 64'(1));
        b_rst_n = 1'b1;
        s_rst_n = 1'b1;
        tick();

        // ---------------- single pixel (5,2) cidx 7 -> addr 645 ----------------
        b_drive(1'b1, 5, 2, 4'd7);
        tick();
        check_value("t1_clip_a", 64'(bif.clip), 64'(0));
        check_value("t1_we_a",   64'(b_mem_we), 64'(0));
        b_drive(1'b0, 0, 0, 4'd0);
        tick();
        check_value("t1_we",     64'(b_mem_we), 64'(1));
        check_value("t1_addr",   64'(b_mem_addr), 64'(645));
        check_value("t1_cidx",   64'(b_mem_cidx), 64'(7));
        check_value("t1_cnt_w",  64'(b_cnt_written), 64'(1));
        check_value("t1_clip_b", 64'(bif.clip), 64'(0));
        tick();
        check_value("t1_we_off", 64'(b_mem_we), 64'(0));
        check_value("t1_cnt_c",  64'(b_cnt_clipped), 64'(0));

        // ---------------- clipping boundaries ----------------
        begin : t2
            int cx [5];
            int cy [5];
            logic [7:0] exp_clip;
            logic [7:0] exp_we;
            cx = '{-1, 320, 0, -32768, 319};
            cy = '{0, 10, 240, 5, 239};
            exp_clip = 8'b0000_1111;
            exp_we   = 8'b0010_0000;
            b_reset();
            for (int c = 0; c < 8; c++) begin
                if (c < 5) b_drive(1'b1, cx[c], cy[c], 4'(c + 1));
                else       b_drive(1'b0, 0, 0, 4'd0);
                tick();
                check_value($sformatf("t2_clip_%0d", c), 64'(bif.clip), 64'(exp_clip[c]));
                check_value($sformatf("t2_we_%0d", c),   64'(b_mem_we), 64'(exp_we[c]));
                if (c == 5) begin
                    check_value("t2_addr", 64'(b_mem_addr), 64'(76799));
                    check_value("t2_cidx", 64'(b_mem_cidx), 64'(5));
                end
            end
            check_value("t2_cnt_c", 64'(b_cnt_clipped), 64'(4));
            check_value("t2_cnt_w", 64'(b_cnt_written), 64'(1));
        end

        // ---------------- streaming 80x80 rectangle at (10,20) ----------------
        begin : t3
            int k_in, n_wr, first_cyc, last_cyc, first_addr, last_addr, bad, exp_a;
            logic adv;
            k_in = 0; n_wr = 0; first_cyc = -1; last_cyc = -1;
            first_addr = -1; last_addr = -1; bad = 0;
            b_reset();
            for (int c = 0; c < 6410; c++) begin
                if (k_in < 6400) b_drive(1'b1, 10 + k_in % 80, 20 + k_in / 80, 4'd3);
                else             b_drive(1'b0, 0, 0, 4'd0);
                adv = bif.we && bif.ready;
                tick();
                if (adv) k_in++;
                if (b_mem_we) begin
                    exp_a = (20 + n_wr / 80) * B_W + 10 + n_wr % 80;
                    if (int'(b_mem_addr) != exp_a || b_mem_cidx != 4'd3) bad++;
                    if (n_wr == 0) begin
                        first_cyc  = c;
                        first_addr = int'(b_mem_addr);
                    end
                    last_cyc  = c;
                    last_addr = int'(b_mem_addr);
                    n_wr++;
                end
            end
            check_value("t3_n_wr",   64'(n_wr), 64'(6400));
            check_value("t3_first",  64'(first_addr), 64'(6410));
            check_value("t3_last",   64'(last_addr), 64'(31769));
            check_value("t3_span",   64'(last_cyc - first_cyc + 1), 64'(6400));
            check_value("t3_bad",    64'(bad), 64'(0));
            check_value("t3_cnt_w",  64'(b_cnt_written), 64'(6400));
            check_value("t3_cnt_c",  64'(b_cnt_clipped), 64'(0));
        end

        // ---------------- reset mid-pipeline ----------------
        b_reset();
        b_drive(1'b1, 5, 2, 4'd7);
        tick();
        b_drive(1'b0, 0, 0, 4'd0);
        b_rst_n = 1'b0;
        tick();
        check_value("t4_we_rst",  64'(b_mem_we), 64'(0));
        b_rst_n = 1'b1;
        tick();
        check_value("t4_we_after", 64'(b_mem_we), 64'(0));
        check_value("t4_cnt_w",    64'(b_cnt_written), 64'(0));

        // ---------------- clear with a pixel in the same cycle ----------------
        begin : t5
            int n_wr, n_busy, n_done, done_cyc, first_cyc, bad;
            n_wr = 0; n_busy = 0; n_done = 0; done_cyc = -1; first_cyc = -1; bad = 0;
            s_reset();
            s_drive(1'b1, 1, 1, 4'd5);
            s_clear_start = 1'b1;
            s_clear_cidx  = 4'd9;
            #1;
            check_value("t5_ready_lo", 64'(sif.ready), 64'(0));
            tick();
            s_clear_start = 1'b0;
            s_drive(1'b0, 0, 0, 4'd0);
            for (int c = 0; c < 260; c++) begin
                if (s_busy) n_busy++;
                if (s_clear_done) begin
                    n_done++;
                    done_cyc = c;
                end
                if (s_mem_we) begin
                    if (n_wr == 0) first_cyc = c;
                    if (int'(s_mem_addr) != n_wr || s_mem_cidx != 4'd9) bad++;
                    n_wr++;
                end
                tick();
            end
            check_value("t5_n_wr",    64'(n_wr), 64'(S_N));
            check_value("t5_first",   64'(first_cyc), 64'(3));
            check_value("t5_bad",     64'(bad), 64'(0));
            check_value("t5_n_busy",  64'(n_busy), 64'(S_N + 2));
            check_value("t5_n_done",  64'(n_done), 64'(1));
            check_value("t5_done_at", 64'(done_cyc), 64'(S_N + 2));
            check_value("t5_ready",   64'(sif.ready), 64'(1));
            check_value("t5_busy",    64'(s_busy), 64'(0));
            check_value("t5_cnt_w",   64'(s_cnt_written), 64'(0));
            check_value("t5_cnt_c",   64'(s_cnt_clipped), 64'(0));
        end

        // ---------------- pixels just before clear, clear_start during CLEAR ----------------
        begin : t6
            int n_wr, n_done, bad, exp_a, exp_c;
            n_wr = 0; n_done = 0; bad = 0;
            s_reset();
            for (int c = 0; c < 320; c++) begin
                s_clear_start = 1'b0;
                s_drive(1'b0, 0, 0, 4'd0);
                if (c == 0) s_drive(1'b1, 2, 1, 4'd4);
                if (c == 1) s_drive(1'b1, 19, 11, 4'd6);
                if (c == 2) begin
                    s_clear_start = 1'b1;
                    s_clear_cidx  = 4'd1;
                end
                if (c == 60) begin
                    s_clear_start = 1'b1;
                    s_clear_cidx  = 4'd8;
                end
                tick();
                if (s_clear_done) n_done++;
                if (s_mem_we) begin
                    if (n_wr == 0)      begin exp_a = 22;  exp_c = 4; end
                    else if (n_wr == 1) begin exp_a = 239; exp_c = 6; end
                    else                begin exp_a = n_wr - 2; exp_c = 1; end
                    if (int'(s_mem_addr) != exp_a || int'(s_mem_cidx) != exp_c) bad++;
                    n_wr++;
                end
            end
            s_clear_start = 1'b0;
            check_value("t6_n_wr",   64'(n_wr), 64'(S_N + 2));
            check_value("t6_bad",    64'(bad), 64'(0));
            check_value("t6_n_done", 64'(n_done), 64'(1));
            check_value("t6_cnt_w",  64'(s_cnt_written), 64'(2));
        end

        // ---------------- reset mid-clear ----------------
        begin : t7
            logic found;
            int n_we, n_done;
            found = 1'b0; n_we = 0; n_done = 0;
            s_reset();
            s_drive(1'b1, 3, 3, 4'd2);
            tick();
            s_drive(1'b0, 0, 0, 4'd0);
            tick();
            s_clear_start = 1'b1;
            s_clear_cidx  = 4'd2;
            tick();
            s_clear_start = 1'b0;
            for (int c = 0; c < 400 && !found; c++) begin
                if (s_mem_we && s_mem_addr == S_AW'(100)) found = 1'b1;
                else tick();
            end
            check_value("t7_reached", 64'(found), 64'(1));
            s_rst_n = 1'b0;
            tick();
            check_value("t7_we",     64'(s_mem_we), 64'(0));
            check_value("t7_busy",   64'(s_busy), 64'(0));
            check_value("t7_done",   64'(s_clear_done), 64'(0));
            check_value("t7_cnt_w",  64'(s_cnt_written), 64'(0));
            check_value("t7_cnt_c",  64'(s_cnt_clipped), 64'(0));
            check_value("t7_ready",  64'(sif.ready), 64'(1));
            s_rst_n = 1'b1;
            for (int c = 0; c < 300; c++) begin
                tick();
                if (s_mem_we) n_we++;
                if (s_clear_done) n_done++;
            end
            check_value("t7_we_after",   64'(n_we), 64'(0));
            check_value("t7_done_after", 64'(n_done), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
